hbram_stream_writer: RTL and testbench

- Upstream feeder for the HyperRAM controller native write path; sits between a 32-bit valid/ready pixel/sample stream and the controller's native_* command/data interface.
- Buffers the stream in an internal synchronous FIFO.
- Issues fixed-length write bursts to a ring of RAM addresses; a flush request forces a partial burst.
- All logic runs in the native clock domain.

---
 rtl/hbram_stream_writer.sv | 204 ++++++++++++++++++++
 tb/tb_hbram_stream_writer.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbram_stream_writer.sv
// Buffers a 32-bit valid/ready stream in a FWFT FIFO and drains it as fixed-length HyperRAM native write bursts over an address ring.
// Optional per-byte write mask: define HBRAM_WR_BYTEMASK_EN to add s_keep and carry it through the FIFO.
module hbram_stream_writer #(
    parameter int unsigned BURST_LEN  = 128,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ADDR_SPAN  = 32'h0080_0000
) (
    input  logic        native_clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
`ifdef HBRAM_WR_BYTEMASK_EN
    input  logic [3:0]  s_keep,
`endif
    input  logic        flush,
    input  logic        hbc_cal_pass,
    input  logic        native_ctrl_idle,
    output logic        native_ram_en,
    output logic        native_ram_rdwr,
    output logic [31:0] native_ram_address,
    output logic [10:0] native_ram_burst_len,
    input  logic        native_wr_buf_ready,
    output logic        native_wr_en,
    output logic [31:0] native_wr_data,
    output logic [3:0]  native_wr_datamask,
    output logic        burst_done,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef HBRAM_WR_BYTEMASK_EN
    localparam int DW = 36;
`else
    localparam int DW = 32;
`endif
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C  = CW'(BURST_LEN);
    localparam logic [10:0]   BURST_L  = 11'(BURST_LEN);
    localparam logic [32:0]   STRIDE   = 33'(BURST_LEN) << 2;
    localparam logic [32:0]   RING_END = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE,
        S_WAIT
    } state_t;

    // ---------------- FIFO ----------------
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] head;
    logic          push;
    logic          pop;
    logic          empty;

`ifdef HBRAM_WR_BYTEMASK_EN
    assign fifo_din = {s_keep, s_data};
`else
    assign fifo_din = s_data;
`endif

    assign s_ready = ~rst & hbc_cal_pass & (count < DEPTH_C);
    assign push    = s_valid & s_ready;
    assign pop     = native_wr_en;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge native_clk) begin
        if (push) begin
            mem[wr_ptr] <= fifo_din;
        end
    end

    always_ff @(posedge native_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- Burst control ----------------
    state_t       state;
    state_t       state_nxt;
    logic [10:0]  len_q;
    logic [10:0]  sent;
    logic [31:0]  addr_q;
    logic [31:0]  ptr;
    logic [31:0]  ptr_adv;
    logic [32:0]  ptr_sum;
    logic [1:0]   wait_cnt;
    logic         flush_pending;
    logic         launch_ok;
    logic         launch;

    assign launch_ok = hbc_cal_pass & native_ctrl_idle &
                       ((count >= BURST_C) | (flush_pending & ~empty));

    // Stride is always a full burst so partial bursts keep the ring slot-aligned.
    assign ptr_sum = {1'b0, ptr} + STRIDE;
    assign ptr_adv = (ptr_sum >= RING_END) ? BASE_ADDR : ptr_sum[31:0];

    always_comb begin
        state_nxt     = state;
        native_ram_en = 1'b0;
        native_wr_en  = 1'b0;
        burst_done    = 1'b0;
        launch        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (launch_ok) begin
                    launch    = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                native_ram_en = 1'b1;
                state_nxt     = S_DATA;
            end
            S_DATA: begin
                native_wr_en = native_wr_buf_ready & (sent < len_q);
                if (native_wr_en && ((sent + 11'd1) == len_q)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                burst_done = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // Controller idle may lag our command; give it time to drop before relaunching.
                if (!native_ctrl_idle || (wait_cnt == 2'd3)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge native_clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            len_q         <= '0;
            sent          <= '0;
            addr_q        <= '0;
            ptr           <= BASE_ADDR;
            wait_cnt      <= '0;
            flush_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                len_q  <= (count >= BURST_C) ? BURST_L : 11'(count);
                addr_q <= ptr;
                sent   <= '0;
            end else if (native_wr_en) begin
                sent <= sent + 11'd1;
            end
            if (state == S_DONE) begin
                ptr      <= ptr_adv;
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            // A flush seen while idle with nothing buffered is simply dropped.
            if (flush) begin
                flush_pending <= 1'b1;
            end else if (launch || ((state == S_IDLE) && empty)) begin
                flush_pending <= 1'b0;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign native_ram_rdwr      = 1'b0;
    assign native_ram_address   = addr_q;
    assign native_ram_burst_len = len_q;
    assign native_wr_data       = empty ? 32'h0 : head[31:0];
`ifdef HBRAM_WR_BYTEMASK_EN
    assign native_wr_datamask   = empty ? 4'h0 : ~head[35:32];
`else
    assign native_wr_datamask   = 4'h0;
`endif
    assign busy = (state != S_IDLE) | ~empty;

endmodule

// File: tb/tb_hbram_stream_writer.sv
// Directed bench for hbram_stream_writer: calibration gate, full/partial bursts, backpressure, ring wrap, reset and byte mask.
module tb_hbram_stream_writer;
    localparam int          BL   = 128;
    localparam int          DEP  = 512;
    localparam logic [31:0] SPAN = 32'h0000_0400;

    logic        native_clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
`ifdef HBRAM_WR_BYTEMASK_EN
    logic [3:0]  s_keep;
`endif
    logic        flush;
    logic        hbc_cal_pass;
    logic        native_ctrl_idle;
    logic        native_ram_en;
    logic        native_ram_rdwr;
    logic [31:0] native_ram_address;
    logic [10:0] native_ram_burst_len;
    logic        native_wr_buf_ready;
    logic        native_wr_en;
    logic [31:0] native_wr_data;
    logic [3:0]  native_wr_datamask;
    logic        burst_done;
    logic        busy;

    hbram_stream_writer #(
        .BURST_LEN (BL),
        .FIFO_DEPTH(DEP),
        .BASE_ADDR (32'h0),
        .ADDR_SPAN (SPAN)
    ) dut (
        .native_clk          (native_clk),
        .rst                 (rst),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .s_data              (s_data),
`ifdef HBRAM_WR_BYTEMASK_EN
        .s_keep              (s_keep),
`endif
        .flush               (flush),
        .hbc_cal_pass        (hbc_cal_pass),
        .native_ctrl_idle    (native_ctrl_idle),
        .native_ram_en       (native_ram_en),
        .native_ram_rdwr     (native_ram_rdwr),
        .native_ram_address  (native_ram_address),
        .native_ram_burst_len(native_ram_burst_len),
        .native_wr_buf_ready (native_wr_buf_ready),
        .native_wr_en        (native_wr_en),
        .native_wr_data      (native_wr_data),
        .native_wr_datamask  (native_wr_datamask),
        .burst_done          (burst_done),
        .busy                (busy)
    );

    always #5 native_clk = ~native_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int viol     = 0;
    bit bp_mode  = 1'b0;
    int rdy_phase = 0;
    logic [31:0] exp_ptr = 32'h0;

    logic [31:0] cmd_addr_q[$];
    logic [10:0] cmd_len_q[$];
    logic [31:0] wr_q[$];
    logic [3:0]  mask_q[$];
    int          wr_cyc_q[$];

    // Ready pattern 1,0,0,1 in backpressure mode, otherwise always ready.
    always @(posedge native_clk) begin
        #1;
        rdy_phase++;
        native_wr_buf_ready = bp_mode ? ((rdy_phase % 4 == 0) || (rdy_phase % 4 == 3)) : 1'b1;
    end

    always @(negedge native_clk) begin
        cyc++;
        if (!rst) begin
            if (native_ram_en) begin
                cmd_addr_q.push_back(native_ram_address);
                cmd_len_q.push_back(native_ram_burst_len);
            end
            if (native_wr_en) begin
                wr_q.push_back(native_wr_data);
                mask_q.push_back(native_wr_datamask);
                wr_cyc_q.push_back(cyc);
                if (!native_wr_buf_ready) viol++;
            end
            if (native_ram_rdwr) viol++;
            if (burst_done) done_cnt++;
        end
    end

    function automatic logic [31:0] next_ptr(input logic [31:0] p);
        return (p + 32'h200 >= SPAN) ? 32'h0 : p + 32'h200;
    endfunction

    task automatic clear_mon();
        cmd_addr_q.delete();
        cmd_len_q.delete();
        wr_q.delete();
        mask_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic push_words(input logic [31:0] first, input int n, output bit ok);
        int i;
        int guard;
        i = 0;
        guard = 0;
        s_valid = 1'b1;
        s_data = first;
        while (i < n && guard < 4000) begin
            @(negedge native_clk);
            if (s_ready) begin
                @(posedge native_clk);
                #1;
                i++;
                s_data = first + 32'(i);
            end else begin
                @(posedge native_clk);
                #1;
            end
            guard++;
        end
        s_valid = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_bursts(input int n, input int budget, output bit ok);
        int target;
        int k;
        target = done_cnt + n;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge native_clk);
            k++;
        end
        repeat (6) @(posedge native_clk);
        #1;
        ok = (done_cnt == target);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge native_clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hbc_cal_pass = 1'b1;
        native_ctrl_idle = 1'b1;
        s_valid = 1'b0;
        s_data = 32'h0;
        flush = 1'b0;
`ifdef HBRAM_WR_BYTEMASK_EN
        s_keep = 4'hF;
`endif
        repeat (3) @(posedge native_clk);
        @(negedge native_clk);
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %0b, want 0", s_ready); end
        n_checks++;
        if ({native_ram_en, native_ram_rdwr, native_wr_en, burst_done, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %05b, want 00000",
                     {native_ram_en, native_ram_rdwr, native_wr_en, burst_done, busy});
        end
        n_checks++;
        if ({native_ram_address, native_ram_burst_len, native_wr_data, native_wr_datamask} !== 79'h0) begin
            n_fail++;
            $display("FAIL reset_buses: addr %h len %0d data %h mask %h, want all 0",
                     native_ram_address, native_ram_burst_len, native_wr_data, native_wr_datamask);
        end
        @(posedge native_clk);
        #1;
        hbc_cal_pass = 1'b0;
        rst = 1'b0;
        @(posedge native_clk);
        #1;
    endtask

    task automatic test_cal_gate();
        clear_mon();
        s_valid = 1'b1;
        s_data = 32'd99;
        for (int i = 0; i < 20; i++) begin
            @(negedge native_clk);
            n_checks++;
            if (s_ready !== 1'b0) begin n_fail++; $display("FAIL cal_gate_s_ready cycle %0d: got %0b, want 0", i, s_ready); end
            @(posedge native_clk);
            #1;
        end
        s_valid = 1'b0;
        n_checks++;
        if (cmd_addr_q.size() !== 0) begin n_fail++; $display("FAIL cal_gate_cmd: got %0d commands, want 0", cmd_addr_q.size()); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cal_gate_busy: got %0b, want 0", busy); end
        hbc_cal_pass = 1'b1;
        @(negedge native_clk);
        n_checks++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL cal_raise_s_ready: got %0b, want 1", s_ready); end
        @(posedge native_clk);
        #1;
    endtask

    task automatic test_full_burst();
        bit ok;
        clear_mon();
        push_words(32'd0, BL, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL full_push: accepted %0b, want 1", ok); end
        wait_bursts(1, 1000, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL full_done: burst_done count %0d, want exactly one more", done_cnt); end
        n_checks++;
        if (cmd_addr_q.size() !== 1) begin
            n_fail++; $display("FAIL full_cmd_count: got %0d, want 1", cmd_addr_q.size());
        end else begin
            n_checks++;
            if (cmd_addr_q[0] !== exp_ptr) begin n_fail++; $display("FAIL full_addr: got %h, want %h", cmd_addr_q[0], exp_ptr); end
            n_checks++;
            if (cmd_len_q[0] !== 11'd128) begin n_fail++; $display("FAIL full_len: got %0d, want 128", cmd_len_q[0]); end
        end
        n_checks++;
        if (wr_q.size() !== BL) begin n_fail++; $display("FAIL full_wr_count: got %0d, want %0d", wr_q.size(), BL); end
        for (int i = 0; i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== 32'(i)) begin n_fail++; $display("FAIL full_data[%0d]: got %0d, want %0d", i, wr_q[i], i); end
        end
        if (wr_cyc_q.size() == BL) begin
            n_checks++;
            if (wr_cyc_q[BL-1] - wr_cyc_q[0] !== BL - 1) begin
                n_fail++; $display("FAIL full_consecutive: span %0d cycles, want %0d", wr_cyc_q[BL-1] - wr_cyc_q[0], BL - 1);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %0b, want 0", busy); end
        exp_ptr = next_ptr(exp_ptr);
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        viol = 0;
        bp_mode = 1'b1;
        push_words(32'd1000, BL, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_push: accepted %0b, want 1", ok); end
        wait_bursts(1, 2000, ok);
        bp_mode = 1'b0;
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_done: burst_done count %0d, want exactly one more", done_cnt); end
        n_checks++;
        if (cmd_addr_q.size() !== 1) begin
            n_fail++; $display("FAIL bp_cmd_count: got %0d, want 1", cmd_addr_q.size());
        end else begin
            n_checks++;
            if (cmd_addr_q[0] !== exp_ptr) begin n_fail++; $display("FAIL bp_addr: got %h, want %h", cmd_addr_q[0], exp_ptr); end
        end
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL bp_wr_without_ready: got %0d, want 0", viol); end
        n_checks++;
        if (wr_q.size() !== BL) begin n_fail++; $display("FAIL bp_wr_count: got %0d, want %0d", wr_q.size(), BL); end
        for (int i = 0; i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== 32'(1000 + i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d, want %0d", i, wr_q[i], 1000 + i); end
        end
        if (wr_cyc_q.size() == BL) begin
            n_checks++;
            if (wr_cyc_q[BL-1] - wr_cyc_q[0] <= BL - 1) begin
                n_fail++; $display("FAIL bp_stalled: span %0d cycles, want more than %0d", wr_cyc_q[BL-1] - wr_cyc_q[0], BL - 1);
            end
        end
        exp_ptr = next_ptr(exp_ptr);
    endtask

    task automatic test_partial_flush();
        bit ok;
        clear_mon();
        push_words(32'd2000, 5, ok);
        repeat (10) @(posedge native_clk);
        #1;
        n_checks++;
        if (cmd_addr_q.size() !== 0) begin n_fail++; $display("FAIL pf_no_early_cmd: got %0d, want 0", cmd_addr_q.size()); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL pf_busy_buffered: got %0b, want 1", busy); end
        pulse_flush();
        wait_bursts(1, 200, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL pf_done: burst_done count %0d, want exactly one more", done_cnt); end
        n_checks++;
        if (cmd_addr_q.size() !== 1) begin
            n_fail++; $display("FAIL pf_cmd_count: got %0d, want 1", cmd_addr_q.size());
        end else begin
            n_checks++;
            if (cmd_addr_q[0] !== exp_ptr) begin n_fail++; $display("FAIL pf_addr: got %h, want %h", cmd_addr_q[0], exp_ptr); end
            n_checks++;
            if (cmd_len_q[0] !== 11'd5) begin n_fail++; $display("FAIL pf_len: got %0d, want 5", cmd_len_q[0]); end
        end
        n_checks++;
        if (wr_q.size() !== 5) begin n_fail++; $display("FAIL pf_wr_count: got %0d, want 5", wr_q.size()); end
        for (int i = 0; i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== 32'(2000 + i)) begin n_fail++; $display("FAIL pf_data[%0d]: got %0d, want %0d", i, wr_q[i], 2000 + i); end
        end
        exp_ptr = next_ptr(exp_ptr);
        // Flush on an empty FIFO must not linger and trigger a later one-word burst.
        pulse_flush();
        repeat (5) @(posedge native_clk);
        #1;
        push_words(32'd2100, 1, ok);
        repeat (15) @(posedge native_clk);
        #1;
        n_checks++;
        if (cmd_addr_q.size() !== 1) begin n_fail++; $display("FAIL pf_empty_flush_cleared: got %0d commands, want 1", cmd_addr_q.size()); end
        pulse_flush();
        wait_bursts(1, 200, ok);
        n_checks++;
        if (cmd_addr_q.size() !== 2) begin
            n_fail++; $display("FAIL pf_one_cmd_count: got %0d, want 2", cmd_addr_q.size());
        end else begin
            n_checks++;
            if (cmd_addr_q[1] !== exp_ptr) begin n_fail++; $display("FAIL pf_one_addr: got %h, want %h", cmd_addr_q[1], exp_ptr); end
            n_checks++;
            if (cmd_len_q[1] !== 11'd1) begin n_fail++; $display("FAIL pf_one_len: got %0d, want 1", cmd_len_q[1]); end
        end
        exp_ptr = next_ptr(exp_ptr);
    endtask

    task automatic test_wrap_full();
        bit ok;
        logic [31:0] ep;
        clear_mon();
        native_ctrl_idle = 1'b0;
        push_words(32'd3000, DEP, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL wf_fill: all %0d accepted %0b, want 1", DEP, ok); end
        s_valid = 1'b1;
        s_data = 32'hDEAD;
        repeat (5) @(posedge native_clk);
        @(negedge native_clk);
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL wf_full_s_ready: got %0b, want 0", s_ready); end
        n_checks++;
        if (cmd_addr_q.size() !== 0) begin n_fail++; $display("FAIL wf_idle_gate: got %0d commands, want 0", cmd_addr_q.size()); end
        @(posedge native_clk);
        #1;
        s_valid = 1'b0;
        native_ctrl_idle = 1'b1;
        wait_bursts(4, 3000, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL wf_done: burst_done count %0d, want 4 more", done_cnt); end
        n_checks++;
        if (cmd_addr_q.size() !== 4) begin
            n_fail++; $display("FAIL wf_cmd_count: got %0d, want 4", cmd_addr_q.size());
        end else begin
            ep = exp_ptr;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (cmd_addr_q[i] !== ep) begin n_fail++; $display("FAIL wf_addr[%0d]: got %h, want %h", i, cmd_addr_q[i], ep); end
                n_checks++;
                if (cmd_len_q[i] !== 11'd128) begin n_fail++; $display("FAIL wf_len[%0d]: got %0d, want 128", i, cmd_len_q[i]); end
                ep = next_ptr(ep);
            end
        end
        n_checks++;
        if (wr_q.size() !== DEP) begin n_fail++; $display("FAIL wf_wr_count: got %0d, want %0d", wr_q.size(), DEP); end
        for (int i = 0; i < wr_q.size(); i++) begin
            if (wr_q[i] !== 32'(3000 + i)) begin
                n_checks++;
                n_fail++;
                $display("FAIL wf_data[%0d]: got %0d, want %0d", i, wr_q[i], 3000 + i);
            end else begin
                n_checks++;
            end
        end
        for (int i = 0; i < 4; i++) exp_ptr = next_ptr(exp_ptr);
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int k;
        clear_mon();
        push_words(32'd3900, 1, ok);
        pulse_flush();
        wait_bursts(1, 200, ok);
        n_checks++;
        if (cmd_addr_q.size() !== 1 || cmd_addr_q[0] !== exp_ptr) begin
            n_fail++; $display("FAIL rm_pre_addr: got %0d commands, want one at %h", cmd_addr_q.size(), exp_ptr);
        end
        exp_ptr = next_ptr(exp_ptr);
        bp_mode = 1'b1;
        push_words(32'd4000, BL, ok);
        k = 0;
        while (wr_q.size() < 11 && k < 2000) begin
            @(posedge native_clk);
            k++;
        end
        #1;
        n_checks++;
        if (cmd_addr_q.size() !== 2 || cmd_addr_q[1] !== exp_ptr) begin
            n_fail++; $display("FAIL rm_burst_start: got %0d commands, want second at %h", cmd_addr_q.size(), exp_ptr);
        end
        rst = 1'b1;
        @(negedge native_clk);
        n_checks++;
        if ({busy, native_wr_en, s_ready} !== 3'b000) begin
            n_fail++; $display("FAIL rm_strobes: busy/wr_en/s_ready got %03b, want 000", {busy, native_wr_en, s_ready});
        end
        n_checks++;
        if (native_ram_address !== 32'h0 || native_ram_burst_len !== 11'd0) begin
            n_fail++; $display("FAIL rm_cmd_regs: addr %h len %0d, want 0 0", native_ram_address, native_ram_burst_len);
        end
        @(posedge native_clk);
        #1;
        rst = 1'b0;
        bp_mode = 1'b0;
        repeat (10) @(posedge native_clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_fifo_emptied: busy %0b, want 0", busy); end
        exp_ptr = 32'h0;
    endtask

    task automatic test_bytemask();
        bit ok;
        logic [3:0] exp_mask [3];
        clear_mon();
`ifdef HBRAM_WR_BYTEMASK_EN
        exp_mask[0] = 4'b0000;
        exp_mask[1] = 4'b1100;
        exp_mask[2] = 4'b0000;
        s_keep = 4'hF;
        push_words(32'd5000, 1, ok);
        s_keep = 4'b0011;
        push_words(32'd5001, 1, ok);
        s_keep = 4'hF;
        push_words(32'd5002, 1, ok);
`else
        exp_mask[0] = 4'b0000;
        exp_mask[1] = 4'b0000;
        exp_mask[2] = 4'b0000;
        push_words(32'd5000, 3, ok);
`endif
        pulse_flush();
        wait_bursts(1, 200, ok);
        n_checks++;
        if (cmd_addr_q.size() !== 1 || cmd_addr_q[0] !== exp_ptr) begin
            n_fail++; $display("FAIL bm_addr_after_reset: got %0d commands, want one at %h", cmd_addr_q.size(), exp_ptr);
        end
        n_checks++;
        if (mask_q.size() !== 3) begin
            n_fail++; $display("FAIL bm_wr_count: got %0d, want 3", mask_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (mask_q[i] !== exp_mask[i]) begin n_fail++; $display("FAIL bm_mask[%0d]: got %b, want %b", i, mask_q[i], exp_mask[i]); end
                n_checks++;
                if (wr_q[i] !== 32'(5000 + i)) begin n_fail++; $display("FAIL bm_data[%0d]: got %0d, want %0d", i, wr_q[i], 5000 + i); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cal_gate();
        test_full_burst();
        test_backpressure();
        test_partial_flush();
        test_wrap_full();
        test_reset_mid_burst();
        test_bytemask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
